// File: rtl/dsp48a1_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
// Optional pre-adder support is selected with the SEQ_PREADD_EN macro.
`timescale 1ns/1ps
package dsp48a1_pkg;

    localparam int unsigned OPND_W = 18;
    localparam int unsigned ACC_W  = 48;
    localparam int unsigned OPM_W  = 8;

    localparam logic [OPM_W-1:0] OPM_MAC_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [OPM_W-1:0] OPM_MAC_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [OPM_W-1:0] OPM_HOLD      = 8'h08;  // X=0, Z=P
    localparam int unsigned      PREADD_BIT    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // OPMODE for an accepted beat; the first beat of a job restarts the sum
    function automatic logic [OPM_W-1:0] beat_opmode(input logic first);
        logic [OPM_W-1:0] opm;
        opm = first ? OPM_MAC_FIRST : OPM_MAC_ACC;
`ifdef SEQ_PREADD_EN
        opm[PREADD_BIT] = 1'b1;
`endif
        return opm;
    endfunction

endpackage

// File: rtl/dsp48a1_opmode_delay.sv
// Fixed-depth shift register aligning OPMODE with the slice's internal
// register stages. DEPTH=0 is a plain wire.
`timescale 1ns/1ps
module dsp48a1_opmode_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        localparam int unsigned SR_W = DEPTH * W;
        logic [SR_W-1:0] sr;

        // Shift a new OPMODE in at the bottom every cycle
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sr <= '0;
            end else begin
                sr <= (sr << W) | SR_W'(din);
            end
        end

        assign dout = sr[SR_W-1 -: W];
    end

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Initiator-side MAC sequencer for one DSP48A1 slice: accepts operand
// beats, drives the slice to accumulate a signed sum of products, waits
// out the pipeline and returns the 48-bit result.
// Optional feature macro: SEQ_PREADD_EN (adds s_d and the pre-adder).
`timescale 1ns/1ps
module dsp48a1_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned OPMODE_LAG = 1,
    parameter int unsigned LEN_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OPND_W-1:0] s_a,
    input  logic [OPND_W-1:0] s_b,
`ifdef SEQ_PREADD_EN
    input  logic [OPND_W-1:0] s_d,
`endif
    input  logic              s_last,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [ACC_W-1:0]  r_data,
    output logic [LEN_W:0]    r_count,
    output logic              r_ovf,
    output logic [OPND_W-1:0] dsp_a,
    output logic [OPND_W-1:0] dsp_b,
    output logic [OPND_W-1:0] dsp_d,
    output logic [ACC_W-1:0]  dsp_c,
    output logic [OPM_W-1:0]  dsp_opmode,
    output logic              dsp_carryin,
    output logic              dsp_ce,
    output logic              dsp_rst,
    input  logic [ACC_W-1:0]  dsp_p
);

    localparam int unsigned DRAIN_LOAD = PIPE_DEPTH + OPMODE_LAG;
    localparam int unsigned DRAIN_W    = (DRAIN_LOAD == 0) ? 1 : $clog2(DRAIN_LOAD + 1);
    localparam logic [LEN_W:0] CNT_MAX = {1'b1, {LEN_W{1'b0}}};

    state_e               state;
    state_e               state_nx;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [OPM_W-1:0]     opm_q;
    logic                 accept_c;
    logic                 first_c;
    logic                 drain_done_c;

    assign accept_c     = s_valid & s_ready;
    assign first_c      = (state == ST_IDLE);
    assign drain_done_c = (drain_cnt == '0);

    assign dsp_c       = '0;
    assign dsp_carryin = 1'b0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (accept_c) begin
                    state_nx = s_last ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_done_c) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_valid && r_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake flags follow the upcoming state so they are glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            s_ready <= (state_nx == ST_IDLE) || (state_nx == ST_RUN);
            r_valid <= (state_nx == ST_DONE);
        end
    end

    // Operand and OPMODE launch; idle cycles send zeros and a P-hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dsp_a <= '0;
            dsp_b <= '0;
            opm_q <= '0;
        end else begin
            dsp_a <= accept_c ? s_a : '0;
            dsp_b <= accept_c ? s_b : '0;
            opm_q <= accept_c ? beat_opmode(first_c) : OPM_HOLD;
        end
    end

`ifdef SEQ_PREADD_EN
    // Pre-adder operand travels with A/B
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dsp_d <= '0;
        end else begin
            dsp_d <= accept_c ? s_d : '0;
        end
    end
`else
    assign dsp_d = '0;
`endif

    dsp48a1_opmode_delay #(
        .DEPTH (OPMODE_LAG),
        .W     (OPM_W)
    ) u_opm_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (opm_q),
        .dout  (dsp_opmode)
    );

    // Drain counter covers the slice pipeline after the last beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (accept_c && s_last) begin
            drain_cnt <= DRAIN_W'(DRAIN_LOAD);
        end else if (state == ST_DRAIN && !drain_done_c) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end

    // Beat counter saturates at 2^LEN_W and flags any beat beyond it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (accept_c) begin
            if (first_c) begin
                r_count <= (LEN_W+1)'(1);
                r_ovf   <= 1'b0;
            end else if (r_count == CNT_MAX) begin
                r_ovf   <= 1'b1;
            end else begin
                r_count <= r_count + (LEN_W+1)'(1);
            end
        end
    end

    // Result capture once the pipeline has fully drained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (state == ST_DRAIN && drain_done_c) begin
            r_data <= dsp_p;
        end
    end

    // Slice enable/reset derived from the block reset
    always_ff @(posedge clk) begin
        dsp_ce  <= rst_n;
        dsp_rst <= ~rst_n;
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed bench for dsp48a1_mac_sequencer with a behavioural DSP48A1
// slice (A1/B1, M, P and OPMODE registers) closing the loop on dsp_p.
`timescale 1ns/1ps
module tb_dsp48a1_mac_sequencer;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
`ifdef SEQ_PREADD_EN
    logic [17:0] s_d;
`endif
    logic        s_last;
    logic        r_valid;
    logic        r_ready;
    logic [47:0] r_data;
    logic [12:0] r_count;
    logic        r_ovf;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [17:0] dsp_d;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin;
    logic        dsp_ce;
    logic        dsp_rst;
    logic [47:0] dsp_p;

    int passed;
    int fails;
    int total;
    int lat;

    dsp48a1_mac_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_a         (s_a),
        .s_b         (s_b),
`ifdef SEQ_PREADD_EN
        .s_d         (s_d),
`endif
        .s_last      (s_last),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_count     (r_count),
        .r_ovf       (r_ovf),
        .dsp_a       (dsp_a),
        .dsp_b       (dsp_b),
        .dsp_d       (dsp_d),
        .dsp_c       (dsp_c),
        .dsp_opmode  (dsp_opmode),
        .dsp_carryin (dsp_carryin),
        .dsp_ce      (dsp_ce),
        .dsp_rst     (dsp_rst),
        .dsp_p       (dsp_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice: A1/B1/D at stage 1, M at stage 2, P at stage 3
    logic signed [17:0] a1;
    logic signed [17:0] b1;
    logic signed [17:0] d1;
    logic        [7:0]  opm_r;
    logic signed [18:0] pre;
    logic signed [47:0] m_r;
    logic signed [47:0] p_r;
    logic signed [47:0] xsel;
    logic signed [47:0] zsel;

    always_comb begin
        pre = {b1[17], b1};
        if (dsp_opmode[4]) pre = pre + {d1[17], d1};
        xsel = (opm_r[1:0] == 2'b01) ? m_r : 48'sd0;
        zsel = (opm_r[3:2] == 2'b10) ? p_r : 48'sd0;
    end

    always_ff @(posedge clk) begin
        if (dsp_rst) begin
            a1 <= '0; b1 <= '0; d1 <= '0; opm_r <= '0; m_r <= '0; p_r <= '0;
        end else if (dsp_ce) begin
            a1    <= dsp_a;
            b1    <= dsp_b;
            d1    <= dsp_d;
            opm_r <= dsp_opmode;
            m_r   <= pre * a1;
            p_r   <= xsel + zsel;
        end
    end

    assign dsp_p = p_r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [17:0] a, input logic [17:0] b, input logic last);
        int guard;
        @(negedge clk);
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_last  = last;
        guard   = 0;
        while (!s_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check("beat_accept_timeout", 64'(s_ready), 64'd1);
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            n++;
            if (r_valid) break;
        end
        if (!r_valid) check("result_timeout", 64'(r_valid), 64'd1);
    endtask

    task automatic collect();
        @(negedge clk);
        r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_ready = 1'b0;
        check("collect_rvalid", 64'(r_valid), 64'd0);
        check("collect_sready", 64'(s_ready), 64'd1);
    endtask

    initial begin
        passed  = 0;
        fails   = 0;
        total   = 0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_last  = 1'b0;
        r_ready = 1'b0;
`ifdef SEQ_PREADD_EN
        s_d     = '0;
`endif

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sready", 64'(s_ready), 64'd0);
        check("rst_rvalid", 64'(r_valid), 64'd0);
        check("rst_rdata", 64'(r_data), 64'd0);
        check("rst_rcount", 64'(r_count), 64'd0);
        check("rst_rovf", 64'(r_ovf), 64'd0);
        check("rst_dsp_a", 64'(dsp_a), 64'd0);
        check("rst_dsp_b", 64'(dsp_b), 64'd0);
        check("rst_opmode", 64'(dsp_opmode), 64'h00);
        check("rst_ce", 64'(dsp_ce), 64'd0);
        check("rst_dsprst", 64'(dsp_rst), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_sready", 64'(s_ready), 64'd1);
        check("post_rst_ce", 64'(dsp_ce), 64'd1);
        check("post_rst_dsprst", 64'(dsp_rst), 64'd0);
        check("dsp_c_tied", 64'(dsp_c), 64'd0);
        check("dsp_carryin_tied", 64'(dsp_carryin), 64'd0);
`ifndef SEQ_PREADD_EN
        check("dsp_d_tied", 64'(dsp_d), 64'd0);
`endif

        // Single beat 2*5
        beat(18'd2, 18'd5, 1'b1);
        wait_result(lat);
        check("single_latency", 64'(lat), 64'd6);
        check("single_data", 64'(r_data), 64'd10);
        check("single_count", 64'(r_count), 64'd1);
        check("single_ovf", 64'(r_ovf), 64'd0);
        check("single_done_sready", 64'(s_ready), 64'd0);
        collect();
        @(negedge clk);
        check("idle_opmode_hold", 64'(dsp_opmode), 64'h08);
        check("idle_dsp_a", 64'(dsp_a), 64'd0);

        // Back-to-back beats: 10 + 45 + 9
        beat(18'd2, 18'd5, 1'b0);
        beat(18'd5, 18'd9, 1'b0);
        beat(18'd3, 18'd3, 1'b1);
        wait_result(lat);
        check("b2b_latency", 64'(lat), 64'd6);
        check("b2b_data", 64'(r_data), 64'd64);
        check("b2b_count", 64'(r_count), 64'd3);
        collect();

        // Same beats with two bubble cycles between them
        beat(18'd2, 18'd5, 1'b0);
        gap(2);
        beat(18'd5, 18'd9, 1'b0);
        gap(2);
        beat(18'd3, 18'd3, 1'b1);
        wait_result(lat);
        check("gap_data", 64'(r_data), 64'd64);
        check("gap_count", 64'(r_count), 64'd3);
        collect();

        // Negative operand: -1 * 3
        beat(18'h3FFFF, 18'd3, 1'b1);
        wait_result(lat);
        check("neg_data", 64'(r_data), 64'hFFFF_FFFF_FFFD);
        collect();

        // Back-pressure: result held stable for 10 cycles
        beat(18'd6, 18'd7, 1'b1);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rvalid", 64'(r_valid), 64'd1);
            check("bp_rdata", 64'(r_data), 64'd42);
            check("bp_sready", 64'(s_ready), 64'd0);
        end
        check("bp_rcount", 64'(r_count), 64'd1);
        collect();

        // Reset during DRAIN aborts the job
        beat(18'd9, 18'd9, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_rvalid", 64'(r_valid), 64'd0);
        check("mid_rst_sready", 64'(s_ready), 64'd0);
        check("mid_rst_rdata", 64'(r_data), 64'd0);
        check("mid_rst_rcount", 64'(r_count), 64'd0);
        check("mid_rst_opmode", 64'(dsp_opmode), 64'h00);
        check("mid_rst_ce", 64'(dsp_ce), 64'd0);
        check("mid_rst_dsprst", 64'(dsp_rst), 64'd1);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (r_valid) seen = 1'b1;
            end
            check("mid_rst_no_result", 64'(seen), 64'd0);
        end
        beat(18'd4, 18'd4, 1'b1);
        wait_result(lat);
        check("after_rst_data", 64'(r_data), 64'd16);
        check("after_rst_count", 64'(r_count), 64'd1);
        collect();

        // Full-scale 4096 beats: (-2^17)^2 * 2^12 = 2^46
        for (int i = 0; i < 4096; i++) beat(18'h20000, 18'h20000, i == 4095);
        wait_result(lat);
        check("full_data", 64'(r_data), 64'h4000_0000_0000);
        check("full_count", 64'(r_count), 64'h1000);
        check("full_ovf", 64'(r_ovf), 64'd0);
        collect();

        // One beat past saturation sets the overflow flag
        for (int i = 0; i < 4097; i++) beat(18'd1, 18'd1, i == 4096);
        wait_result(lat);
        check("ovf_data", 64'(r_data), 64'd4097);
        check("ovf_count", 64'(r_count), 64'h1000);
        check("ovf_flag", 64'(r_ovf), 64'd1);
        collect();

        // Next job clears the overflow flag
        beat(18'd1, 18'd1, 1'b1);
        wait_result(lat);
        check("ovf_clear", 64'(r_ovf), 64'd0);
        collect();

`ifdef SEQ_PREADD_EN
        // Pre-adder: (4 + 5) * 2
        @(negedge clk);
        s_d = 18'd4;
        beat(18'd2, 18'd5, 1'b1);
        s_d = '0;
        wait_result(lat);
        check("preadd_data", 64'(r_data), 64'd18);
        collect();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
